wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Architectural register file at the downstream end of the writeback stage. It
//  consumes the stage's write address/data and serves two combinational read ports
//  to decode/EX.
//  A pending-write scoreboard lets decode stall on load-use and UART/conv-read hazards.
//  A one-cycle history register supplies a late EX forwarding source.
// PARAMETERS
//  DWIDTH  32  data width of each register
//  AWIDTH  5   register address width; NREGS = 2**AWIDTH = 32
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  wb_we_i      in   1       writeback valid/enable for this cycle
//  wb_addr_i    in   AWIDTH  destination register from writeback stage
//  wb_data_i    in   DWIDTH  writeback data (already forced 0 when addr is x0)
//  rs1_addr_i   in   AWIDTH  read port 1 address
//  rs2_addr_i   in   AWIDTH  read port 2 address
//  rs1_data_o   out  DWIDTH  read port 1 data (combinational)
//  rs2_data_o   out  DWIDTH  read port 2 data (combinational)
//  pend_set_i   in   1       decode issued a long-latency write (load/UART/conv) to pend_addr_i
//  pend_addr_i  in   AWIDTH  destination of that issued write
//  flush_i      in   1       pipeline flush: clear all pending bits
//  rs1_busy_o   out  1       rs1_addr_i has an outstanding pending write
//  rs2_busy_o   out  1       rs2_addr_i has an outstanding pending write
//  fwd_valid_o  out  1       history register holds last cycle's committed write
//  fwd_addr_o   out  AWIDTH  address of that write
//  fwd_data_o   out  DWIDTH  data of that write
// BEHAVIOUR
//  - Reset (rst_n low, async): all 32 regs = 0, pending vector = 0, fwd_valid_o = 0,
//    fwd_addr_o = 0, fwd_data_o = 0. Reads during reset return 0.
//  - Write: at posedge clk, if wb_we_i && wb_addr_i != 0, reg[wb_addr_i] <= wb_data_i.
//    Writes to x0 are dropped; reg[0] is never written and always reads 0.
//  - Read: combinational, write-first bypass. If wb_we_i && wb_addr_i == rsN_addr_i
//    && rsN_addr_i != 0, rsN_data_o = wb_data_i. Else rsN_data_o = reg[rsN_addr_i].
//    rsN_addr_i == 0 always gives 0.
//  - Pending scoreboard: 32-bit vector, bit 0 hardwired 0. Per clock edge:
//      clear bit wb_addr_i if wb_we_i;
//      then set bit pend_addr_i if pend_set_i && pend_addr_i != 0.
//      Same-address set+clear in one cycle: set wins, because the new issue is younger.
//    flush_i: next vector = 0, overriding any set or clear in that cycle.
//    rsN_busy_o = pend[rsN_addr_i] & ~(wb_we_i && wb_addr_i == rsN_addr_i).
//    The in-flight write clears busy combinationally; the bypass supplies the data.
//  - History register: at posedge, fwd_valid_o <= wb_we_i && wb_addr_i != 0.
//    When that is true, fwd_addr_o <= wb_addr_i and fwd_data_o <= wb_data_i.
//    Otherwise addr/data hold their old values. flush_i does not affect the history register.
//  - Latency: write visible on read ports in the same cycle via bypass, and from
//    the array on the next cycle. Busy set is visible the cycle after pend_set_i.
//  - No backpressure: writeback never stalls; every wb_we_i cycle commits.
// TESTING
//  - Reset mid-run: write x5=0xDEADBEEF, assert rst_n=0 asynchronously
//    -> rs1(x5)=0, busy=0, fwd_valid_o=0 immediately.
//  - x0 guard: wb_we_i=1, addr=0, data=0x12345678 -> rs1(x0)=0,
//    fwd_valid_o=0 next cycle, pend bit 0 never set.
//  - Bypass: same cycle write x7=0xA5A5A5A5 and read rs1=x7, rs2=x7
//    -> both 0xA5A5A5A5. Next cycle array read also gives 0xA5A5A5A5.
//  - Load-use: pend_set x9 at cycle N -> rs2_busy(x9)=1 from N+1. At writeback
//    cycle M, wb_we x9 -> busy=0 in M and data bypassed. Bit is clear at M+1.
//  - Set/clear collision: wb_we x3 and pend_set x3 in the same cycle
//    -> rs1_busy(x3)=1 next cycle. The same collision with flush_i=1 -> busy=0.
//  - History: write x12=0x00000042, then idle cycle -> fwd_valid_o=1,
//    fwd_addr_o=12, fwd_data_o=0x42, then fwd_valid_o=0 with addr/data held.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Architectural register file sitting at the tail of the writeback stage.
//   Holds NREGS = 2**AWIDTH registers (x0 hardwired to zero), serves two
//   combinational read ports with a write-first bypass, tracks outstanding
//   long-latency writes in a pending scoreboard so decode can stall, and keeps
//   a one-cycle history of the last committed write as a late EX forward.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_we_i/wb_addr_i/wb_data_i writeback enable, destination, data
//   rs1_addr_i, rs2_addr_i     read addresses
//   rs1_data_o, rs2_data_o     read data (combinational, bypassed)
//   pend_set_i, pend_addr_i    mark a destination as having a write in flight
//   flush_i                    drop every pending mark
//   rs1_busy_o, rs2_busy_o     read address has a write still in flight
//   fwd_valid_o/addr_o/data_o  last cycle's committed write
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we_i,
  input  logic [AWIDTH-1:0] wb_addr_i,
  input  logic [DWIDTH-1:0] wb_data_i,
  input  logic [AWIDTH-1:0] rs1_addr_i,
  input  logic [AWIDTH-1:0] rs2_addr_i,
  output logic [DWIDTH-1:0] rs1_data_o,
  output logic [DWIDTH-1:0] rs2_data_o,
  input  logic              pend_set_i,
  input  logic [AWIDTH-1:0] pend_addr_i,
  input  logic              flush_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              fwd_valid_o,
  output logic [AWIDTH-1:0] fwd_addr_o,
  output logic [DWIDTH-1:0] fwd_data_o
);

  localparam int NREGS = 1 << AWIDTH;

  logic [DWIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_next;
  logic              wb_commit;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              rs1_wb_match;
  logic              rs2_wb_match;

  // A writeback only commits when it targets a real register; x0 writes are
  // dropped everywhere (array, bypass, history).
  assign wb_commit = wb_we_i && (wb_addr_i != '0);

  // Register array. Entry 0 is reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_commit) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // Address matches between the in-flight writeback and each read port.
  assign rs1_wb_match = wb_we_i && (wb_addr_i == rs1_addr_i);
  assign rs2_wb_match = wb_we_i && (wb_addr_i == rs2_addr_i);

  // Bypass is gated by rst_n so reads return zero while reset is held, even
  // if the writeback stage still presents a write.
  assign rs1_hit = rst_n && rs1_wb_match && (rs1_addr_i != '0);
  assign rs2_hit = rst_n && rs2_wb_match && (rs2_addr_i != '0);

  always_comb begin
    rs1_data_o = '0;
    if (rs1_addr_i != '0) begin
      rs1_data_o = rs1_hit ? wb_data_i : regs[rs1_addr_i];
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (rs2_addr_i != '0) begin
      rs2_data_o = rs2_hit ? wb_data_i : regs[rs2_addr_i];
    end
  end

  // Scoreboard update order: clear on writeback, then set on issue (the
  // issue is younger, so it wins a same-address collision), then flush
  // overrides both. Bit 0 is forced low so x0 never reads as busy.
  always_comb begin
    pend_next = pend;
    if (wb_we_i) begin
      pend_next[wb_addr_i] = 1'b0;
    end
    if (pend_set_i && (pend_addr_i != '0)) begin
      pend_next[pend_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_next = '0;
    end
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  // The write arriving this cycle releases the stall immediately; the bypass
  // supplies its data in the same cycle.
  assign rs1_busy_o = pend[rs1_addr_i] & ~rs1_wb_match;
  assign rs2_busy_o = pend[rs2_addr_i] & ~rs2_wb_match;

  // History register. Address/data only load on a committed write so a late
  // consumer still sees the last value after valid drops. Flush is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_o <= 1'b0;
      fwd_addr_o  <= '0;
      fwd_data_o  <= '0;
    end else begin
      fwd_valid_o <= wb_commit;
      if (wb_commit) begin
        fwd_addr_o <= wb_addr_i;
        fwd_data_o <= wb_data_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile: a table of directed vectors with
//   hand-computed expectations, plus hand-written sequences for reset
//   mid-run and the post-reset state.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        pend_set_i;
  logic [4:0]  pend_addr_i;
  logic        flush_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        pset;
    logic [4:0]  paddr;
    logic        flush;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic        e_fv;
    logic [4:0]  e_fa;
    logic [31:0] e_fd;
  } vec_t;

  vec_t vecs[$];

  wb_regfile #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_we_i     (wb_we_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .pend_set_i  (pend_set_i),
    .pend_addr_i (pend_addr_i),
    .flush_i     (flush_i),
    .rs1_busy_o  (rs1_busy_o),
    .rs2_busy_o  (rs2_busy_o),
    .fwd_valid_o (fwd_valid_o),
    .fwd_addr_o  (fwd_addr_o),
    .fwd_data_o  (fwd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic pset, input logic [4:0] paddr, input logic flush,
    input logic [31:0] e_d1, input logic [31:0] e_d2,
    input logic e_b1, input logic e_b2,
    input logic e_fv, input logic [4:0] e_fa, input logic [31:0] e_fd);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.r1 = r1; v.r2 = r2;
    v.pset = pset; v.paddr = paddr; v.flush = flush;
    v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_fv = e_fv; v.e_fa = e_fa; v.e_fd = e_fd;
    return v;
  endfunction

  // Drives one cycle's inputs (blocking), then lets combinational paths settle.
  task automatic applyStimulus(input vec_t v);
    wb_we_i     = v.we;
    wb_addr_i   = v.waddr;
    wb_data_i   = v.wdata;
    rs1_addr_i  = v.r1;
    rs2_addr_i  = v.r2;
    pend_set_i  = v.pset;
    pend_addr_i = v.paddr;
    flush_i     = v.flush;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " rs1_data"}, rs1_data_o, v.e_d1);
    checkOutput({tag, " rs2_data"}, rs2_data_o, v.e_d2);
    checkOutput({tag, " rs1_busy"}, {31'd0, rs1_busy_o}, {31'd0, v.e_b1});
    checkOutput({tag, " rs2_busy"}, {31'd0, rs2_busy_o}, {31'd0, v.e_b2});
    checkOutput({tag, " fwd_valid"}, {31'd0, fwd_valid_o}, {31'd0, v.e_fv});
    checkOutput({tag, " fwd_addr"}, {27'd0, fwd_addr_o}, {27'd0, v.e_fa});
    checkOutput({tag, " fwd_data"}, fwd_data_o, v.e_fd);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fields: we waddr wdata | r1 r2 | pset paddr flush | d1 d2 b1 b2 | fv fa fd
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    // Bypass on both ports, then array read next cycle.
    vecs.push_back(mk(1, 7, 32'hA5A5A5A5, 7, 7,  0, 0, 0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            7, 0,  0, 0, 0,  32'hA5A5A5A5, 0, 0, 0,  1, 7, 32'hA5A5A5A5));
    // x0 guard: write dropped, no bypass, history not loaded.
    vecs.push_back(mk(1, 0, 32'h12345678, 0, 7,  0, 0, 0,  0, 32'hA5A5A5A5, 0, 0,  0, 7, 32'hA5A5A5A5));
    // Load-use on x9: issue, busy next cycle, cleared by writeback.
    vecs.push_back(mk(0, 0, 0,            9, 9,  1, 9, 0,  0, 0, 0, 0,  0, 7, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0, 0,            0, 9,  0, 0, 0,  0, 0, 0, 1,  0, 7, 32'hA5A5A5A5));
    vecs.push_back(mk(1, 9, 32'h11112222, 9, 9,  0, 0, 0,  32'h11112222, 32'h11112222, 0, 0,  0, 7, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0, 0,            9, 9,  0, 0, 0,  32'h11112222, 32'h11112222, 0, 0,  1, 9, 32'h11112222));
    // Set/clear collision on x3: set wins.
    vecs.push_back(mk(1, 3, 32'h33,       3, 0,  1, 3, 0,  32'h33, 0, 0, 0,  0, 9, 32'h11112222));
    vecs.push_back(mk(0, 0, 0,            3, 0,  0, 0, 0,  32'h33, 0, 1, 0,  1, 3, 32'h33));
    // Same collision under flush: bit ends clear.
    vecs.push_back(mk(1, 3, 32'h44,       3, 0,  1, 3, 1,  32'h44, 0, 0, 0,  0, 3, 32'h33));
    vecs.push_back(mk(0, 0, 0,            3, 0,  0, 0, 0,  32'h44, 0, 0, 0,  1, 3, 32'h44));
    // History: x12 write, then idle cycles hold addr/data.
    vecs.push_back(mk(1, 12, 32'h42,      12, 3, 0, 0, 0,  32'h42, 32'h44, 0, 0,  0, 3, 32'h44));
    vecs.push_back(mk(0, 0, 0,            12, 0, 0, 0, 0,  32'h42, 0, 0, 0,  1, 12, 32'h42));
    vecs.push_back(mk(0, 0, 0,            12, 0, 0, 0, 0,  32'h42, 0, 0, 0,  0, 12, 32'h42));
    // Pending set on x0 is ignored.
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 0, 0,  0, 0, 0, 0,  0, 12, 32'h42));
    vecs.push_back(mk(0, 0, 0,            0, 12, 0, 0, 0,  0, 32'h42, 0, 0,  0, 12, 32'h42));
    // Flush alone clears a pending bit at the edge, not before.
    vecs.push_back(mk(0, 0, 0,            5, 0,  1, 5, 0,  0, 0, 0, 0,  0, 12, 32'h42));
    vecs.push_back(mk(0, 0, 0,            5, 0,  0, 0, 1,  0, 0, 1, 0,  0, 12, 32'h42));
    vecs.push_back(mk(0, 0, 0,            5, 0,  0, 0, 0,  0, 0, 0, 0,  0, 12, 32'h42));
    // Writeback to a different register does not release a busy bit.
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 9, 0,  0, 0, 0, 0,  0, 12, 32'h42));
    vecs.push_back(mk(1, 8, 32'h8,        8, 9,  0, 0, 0,  32'h8, 32'h11112222, 0, 1,  0, 12, 32'h42));
    vecs.push_back(mk(0, 0, 0,            8, 9,  0, 0, 0,  32'h8, 32'h11112222, 0, 1,  1, 8, 32'h8));

    // Reset state with inputs quiet.
    rst_n = 1'b0;
    applyStimulus(idle);
    checkAll("reset", idle);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-run: commit x5 and a pending x6, then drop rst_n between edges.
    @(negedge clk);
    applyStimulus(mk(1, 5, 32'hDEADBEEF, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("pre-reset rs1 x5", rs1_data_o, 32'hDEADBEEF);
    checkOutput("pre-reset rs2_busy x6", {31'd0, rs2_busy_o}, 32'd1);
    checkOutput("pre-reset fwd_valid", {31'd0, fwd_valid_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset rs1 x5", rs1_data_o, 32'h0);
    checkOutput("async reset rs2_busy", {31'd0, rs2_busy_o}, 32'd0);
    checkOutput("async reset fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
    checkOutput("async reset fwd_data", fwd_data_o, 32'h0);
    // A writeback presented while reset is held must not bypass.
    applyStimulus(mk(1, 5, 32'hCAFEF00D, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("reset-held bypass", rs1_data_o, 32'h0);
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset rs1 x5", rs1_data_o, 32'h0);
    checkOutput("post-reset rs2 x7", rs2_data_o, 32'h0);
    @(negedge clk);
    checkOutput("post-reset fwd_valid", {31'd0, fwd_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
